ram16_responder: RTL
====================

Name: ram16_responder

Overview:
- Memory-side responder for the 16-bit half-word bus driven by the pipeline memory controller.
- The controller splits every 32-bit fetch, load or store into two consecutive 16-bit beats (HI then LO) on an 18-bit half-word address.
- This block stores the half-words, returns read data on the shared tri-state bus, checks beat pairing, and counts completed 32-bit transfers.
- A preload port lets benches and boot logic fill program memory before reset is released.

Parameters:
ADDR_W, 18, half-word address width on the bus
DATA_W, 16, bus data width
DEPTH, 4096, implemented half-words; power of two; index = addr[log2(DEPTH)-1:0]
CNT_W, 16, width of the transfer counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
mc_ram_en  in  1  beat valid; tie high when the controller accesses every cycle
mc_ram_addr  in  ADDR_W  half-word address
mc_ram_wre  in  1  0 = write beat, 1 = read beat
mc_ram_data  inout  DATA_W  shared bus; driven only while returning read data
ld_en  in  1  preload write strobe
ld_addr  in  ADDR_W  preload half-word address
ld_data  in  DATA_W  preload data
rd_count  out  CNT_W  completed 32-bit read pairs, saturating
wr_count  out  CNT_W  completed 32-bit write pairs, saturating
pair_err  out  1  sticky beat-pairing violation
oor  out  1  sticky: an access had address >= DEPTH (aliased)
ld_collide  out  1  sticky: a bus write was dropped because of preload

Behaviour:
- Reset (async, low):
  - drive_en=0, so the bus goes to Z immediately.
  - rd_q=0, rd_count=0, wr_count=0; pair_err, oor and ld_collide all 0; FSM=EXP_HI.
  - Memory array contents are retained across reset.
- Write beat (posedge, en=1, wre=0): mem[idx] <= mc_ram_data; the bus is never driven by this block in the same cycle.
- Read beat (posedge, en=1, wre=1): rd_q <= mem[idx]; drive_en <= 1.
  - Latency: 1 cycle. Data appears after the sampling edge and stays valid until the next edge.
  - mc_ram_data = (drive_en & mc_ram_wre) ? rd_q : Z. Drive drops combinationally if the controller pulls wre low, so there is no contention.
  - drive_en <= 0 on any edge without a read beat.
- Read-after-write to the same address on consecutive beats returns the newly written data. Same-edge write then read ordering is handled by the previous edge.
- Preload (posedge, ld_en=1): mem[ld_addr idx] <= ld_data.
  - A simultaneous bus read is still serviced and returns pre-preload data.
  - A simultaneous bus write is dropped and sets ld_collide.
  - Preload does not advance the FSM.
- oor is set on any bus beat with mc_ram_addr >= DEPTH. The access still proceeds on the aliased index.
- Pairing FSM (advances only on beats with en=1):
  - EXP_HI: latch a_hi=addr and dir=wre, go to EXP_LO.
  - EXP_LO: if addr != a_hi+1 (mod 2^ADDR_W) or wre != dir, set pair_err; otherwise increment rd_count (dir=1) or wr_count (dir=0). Return to EXP_HI in both cases.
  - en=0 holds the state, so stalls between beats are legal.
  - Address wrap 0x3FFFF -> 0x00000 is a legal pair.
- Counters saturate at 2^CNT_W-1.

Test Plan:
- Preload mem[0x10]=0xDEAD, mem[0x11]=0xBEEF with reset high; read beats 0x10, 0x11 on consecutive edges -> bus shows 0xDEAD then 0xBEEF one cycle after each edge; rd_count=1, pair_err=0.
- Write pair 0x20=0x1234, 0x21=0x5678, then read pair 0x20/0x21 -> returns 0x1234, 0x5678; wr_count=1, rd_count=1; bus is Z during both write cycles.
- Read beat 0x30 then write beat 0x31 -> pair_err=1, no counter change; FSM back to EXP_HI, so a following proper pair 0x40/0x41 increments rd_count.
- Assert reset low mid-read (drive_en=1) -> bus goes Z without a clock edge; counters clear; after release, mem[0x20] still reads 0x1234.
- ld_en together with a bus write to 0x50, data 0xAAAA -> bus write dropped, ld_collide=1, mem holds ld_data. Separately, a read of 0x1005 with DEPTH=4096 -> oor=1 and the data of mem[0x005] is returned.
- Force rd_count to 0xFFFF via 65535 read pairs, then one more pair -> count stays 0xFFFF.

Source files
------------

// File: rtl/ram16_responder.sv
// ram16_responder
//   Memory-side responder for the 16-bit half-word bus of the pipeline memory
//   controller. Every 32-bit access arrives as two beats (HI then LO). This
//   block stores half-words, returns read data on the shared tri-state bus one
//   cycle after a read beat, checks that beats pair up correctly, and counts
//   completed 32-bit read and write pairs.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset (memory contents retained)
//   mc_ram_en    beat valid
//   mc_ram_addr  half-word address (aliased onto DEPTH entries)
//   mc_ram_wre   0 = write beat, 1 = read beat
//   mc_ram_data  shared bus; driven only while returning read data
//   ld_en        preload write strobe (has priority over bus writes)
//   ld_addr      preload half-word address
//   ld_data      preload data
//   rd_count     completed read pairs, saturating
//   wr_count     completed write pairs, saturating
//   pair_err     sticky beat-pairing violation
//   oor          sticky: a bus beat addressed >= DEPTH
//   ld_collide   sticky: a bus write was dropped because of a preload
module ram16_responder #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mc_ram_en,
    input  logic [ADDR_W-1:0] mc_ram_addr,
    input  logic              mc_ram_wre,
    inout  logic [DATA_W-1:0] mc_ram_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              pair_err,
    output logic              oor,
    output logic              ld_collide
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        EXP_HI,
        EXP_LO
    } pair_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  ld_idx;
    logic              addr_oor;
    logic              beat_rd;
    logic              beat_wr;

    logic [DATA_W-1:0] rd_q;
    logic              drive_en;

    pair_state_t       state, state_nx;
    logic [ADDR_W-1:0] a_hi, a_hi_nx;
    logic [ADDR_W-1:0] a_hi_inc;
    logic              dir, dir_nx;
    logic [CNT_W-1:0]  rd_count_nx;
    logic [CNT_W-1:0]  wr_count_nx;
    logic              pair_err_nx;
    logic              oor_nx;
    logic              ld_collide_nx;

    assign idx     = mc_ram_addr[IDX_W-1:0];
    assign ld_idx  = ld_addr[IDX_W-1:0];
    assign beat_rd = mc_ram_en &  mc_ram_wre;
    assign beat_wr = mc_ram_en & ~mc_ram_wre;

    // Address bits above the implemented index: any set bit on a bus beat is
    // out of range. Preload addresses alias silently.
    generate
        if (ADDR_W > IDX_W) begin : g_hi_bits
            logic unused_ld_hi;
            assign addr_oor     = |mc_ram_addr[ADDR_W-1:IDX_W];
            assign unused_ld_hi = ^ld_addr[ADDR_W-1:IDX_W];
        end else begin : g_no_hi_bits
            assign addr_oor = 1'b0;
        end
    endgenerate

    // Single write port: preload wins, a simultaneous bus write is dropped.
    // Bus writes are ignored while in reset; preload works regardless so boot
    // logic can fill memory before reset is released.
    always_ff @(posedge clock) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end else if (beat_wr && reset) begin
            mem[idx] <= mc_ram_data;
        end
    end

    // Read data register. Non-blocking semantics make a same-edge preload
    // invisible to the read, which returns the pre-preload contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q     <= '0;
            drive_en <= 1'b0;
        end else begin
            drive_en <= beat_rd;
            if (beat_rd) begin
                rd_q <= mem[idx];
            end
        end
    end

    // Gating with the live wre lets the controller take the bus back mid-cycle
    // without contention.
    assign mc_ram_data = (drive_en && mc_ram_wre) ? rd_q : 'z;

    assign a_hi_inc = a_hi + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= EXP_HI;
            a_hi       <= '0;
            dir        <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
            pair_err   <= 1'b0;
            oor        <= 1'b0;
            ld_collide <= 1'b0;
        end else begin
            state      <= state_nx;
            a_hi       <= a_hi_nx;
            dir        <= dir_nx;
            rd_count   <= rd_count_nx;
            wr_count   <= wr_count_nx;
            pair_err   <= pair_err_nx;
            oor        <= oor_nx;
            ld_collide <= ld_collide_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        a_hi_nx       = a_hi;
        dir_nx        = dir;
        rd_count_nx   = rd_count;
        wr_count_nx   = wr_count;
        pair_err_nx   = pair_err;
        oor_nx        = oor;
        ld_collide_nx = ld_collide;

        if (mc_ram_en && addr_oor) begin
            oor_nx = 1'b1;
        end
        if (ld_en && beat_wr) begin
            ld_collide_nx = 1'b1;
        end

        // Only bus beats advance pairing; idle cycles between HI and LO are
        // legal stalls.
        case (state)
            EXP_HI: begin
                if (mc_ram_en) begin
                    a_hi_nx  = mc_ram_addr;
                    dir_nx   = mc_ram_wre;
                    state_nx = EXP_LO;
                end
            end
            EXP_LO: begin
                if (mc_ram_en) begin
                    state_nx = EXP_HI;
                    if (mc_ram_addr != a_hi_inc || mc_ram_wre != dir) begin
                        pair_err_nx = 1'b1;
                    end else if (dir) begin
                        if (rd_count != '1) begin
                            rd_count_nx = rd_count + CNT_W'(1);
                        end
                    end else begin
                        if (wr_count != '1) begin
                            wr_count_nx = wr_count + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_nx = EXP_HI;
        endcase
    end

endmodule
